sfifo1f_2f: RTL and testbench

//  Synchronous FIFO with a registered write-side staging entry: a 1-entry input stage feeding a
//  2**DEPTH_BITS-entry storage FIFO with show-ahead output. Write-side counterpart of the

---
 rtl/sfifo1f_2f_pkg.sv | 12 +
 rtl/sfifo1f_stage.sv | 30 +++
 rtl/sfifo1f_2f.sv | 95 +++++++++
 tb/tb_sfifo1f_2f.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/sfifo1f_2f_pkg.sv
// Shared defaults and sizing helper for the staged-write FIFO.
package sfifo1f_2f_pkg;

    localparam int DEF_WIDTH      = 16;
    localparam int DEF_DEPTH_BITS = 3;

    // Total capacity: storage entries plus the single staging entry.
    function automatic int cap_of(input int depth_bits);
        return (1 << depth_bits) + 1;
    endfunction

endpackage

// File: rtl/sfifo1f_stage.sv
// One-entry registered write stage in front of the storage array.
module sfifo1f_stage
    import sfifo1f_2f_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             wr,
    input  logic             drain,
    output logic [WIDTH-1:0] data,
    output logic             valid
);

    // Capture on write; a write into a draining stage keeps it valid so
    // back-to-back writes run at one word per clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data  <= '0;
            valid <= 1'b0;
        end else if (wr) begin
            data  <= din;
            valid <= 1'b1;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/sfifo1f_2f.sv
// Synchronous FIFO: registered 1-entry write stage feeding a show-ahead
// storage FIFO. All flags come from registered state only.
module sfifo1f_2f
    import sfifo1f_2f_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int DEPTH_BITS = DEF_DEPTH_BITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH-1:0]      din,
    input  logic                  wr,
    input  logic                  rd,
    output logic [WIDTH-1:0]      dout,
    output logic [DEPTH_BITS:0]   count,
    output logic [DEPTH_BITS:0]   ncount,
    output logic                  full,
    output logic                  empty,
    output logic                  fullm1,
    output logic                  emptyp2
);

    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam int CAP   = cap_of(DEPTH_BITS);
    localparam int CW    = DEPTH_BITS + 1;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_BITS-1:0] wptr;
    logic [DEPTH_BITS-1:0] rptr;
    logic [CW-1:0]         scnt;
    logic [WIDTH-1:0]      stage_data;
    logic                  stage_v;
    logic                  stor_full;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  drain;

    assign stor_full = (scnt == CW'(DEPTH));
    assign empty     = (scnt == '0);
    assign full      = stage_v & stor_full;
    assign wr_acc    = wr & ~full;
    assign rd_acc    = rd & ~empty;
    // A pop on the same edge frees the slot the stage drains into.
    assign drain     = stage_v & (~stor_full | rd_acc);

    sfifo1f_stage #(
        .WIDTH (WIDTH)
    ) u_stage (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (din),
        .wr    (wr_acc),
        .drain (drain),
        .data  (stage_data),
        .valid (stage_v)
    );

    // Storage array write port; contents need no reset since empty gates dout.
    always_ff @(posedge clk) begin
        if (drain) begin
            mem[wptr] <= stage_data;
        end
    end

    // Pointers and storage occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            scnt <= '0;
        end else begin
            if (drain) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_acc) begin
                rptr <= rptr + 1'b1;
            end
            case ({drain, rd_acc})
                2'b10:   scnt <= scnt + 1'b1;
                2'b01:   scnt <= scnt - 1'b1;
                default: scnt <= scnt;
            endcase
        end
    end

    // Occupancy and threshold flags from registered stage/storage state.
    always_comb begin
        count   = scnt + {{DEPTH_BITS{1'b0}}, stage_v};
        ncount  = CW'(CAP) - count;
        fullm1  = (count >= CW'(CAP - 1));
        emptyp2 = (count <= CW'(2));
        dout    = empty ? '0 : mem[rptr];
    end

endmodule

// File: tb/tb_sfifo1f_2f.sv
// Self-checking bench for sfifo1f_2f: directed scenarios then random traffic,
// compared against a queue-based reference model.
module tb_sfifo1f_2f;

    localparam int W     = 16;
    localparam int DEPTH = 8;
    localparam int CAP   = 9;

    logic          clk;
    logic          rst_n;
    logic [W-1:0]  din;
    logic          wr;
    logic          rd;
    logic [W-1:0]  dout;
    logic [3:0]    count;
    logic [3:0]    ncount;
    logic          full;
    logic          empty;
    logic          fullm1;
    logic          emptyp2;

    int checks = 0;
    int errors = 0;

    // Reference model: readable storage queue plus the not-yet-readable staged word.
    logic [W-1:0] stor[$];
    bit           m_sv;
    logic [W-1:0] m_sd;

    sfifo1f_2f #(.WIDTH(W), .DEPTH_BITS(3)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .din     (din),
        .wr      (wr),
        .rd      (rd),
        .dout    (dout),
        .count   (count),
        .ncount  (ncount),
        .full    (full),
        .empty   (empty),
        .fullm1  (fullm1),
        .emptyp2 (emptyp2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_count();
        return stor.size() + (m_sv ? 1 : 0);
    endfunction

    task automatic m_reset();
        stor.delete();
        m_sv = 1'b0;
        m_sd = '0;
    endtask

    task automatic m_step(input bit w, input bit r, input logic [W-1:0] d);
        bit m_full;
        bit ra;
        bit wa;
        bit dr;
        m_full = m_sv && (stor.size() == DEPTH);
        ra     = r && (stor.size() > 0);
        wa     = w && !m_full;
        dr     = m_sv && ((stor.size() < DEPTH) || ra);
        if (ra) void'(stor.pop_front());
        if (dr) stor.push_back(m_sd);
        if (wa) begin
            m_sd = d;
            m_sv = 1'b1;
        end else if (dr) begin
            m_sv = 1'b0;
        end
    endtask

    task automatic chk_all(input string tag);
        int c;
        c = m_count();
        chk({tag, ".count"},   32'(count),   32'(c));
        chk({tag, ".ncount"},  32'(ncount),  32'(CAP - c));
        chk({tag, ".full"},    32'(full),    32'((m_sv && stor.size() == DEPTH) ? 1 : 0));
        chk({tag, ".empty"},   32'(empty),   32'((stor.size() == 0) ? 1 : 0));
        chk({tag, ".fullm1"},  32'(fullm1),  32'((c >= CAP - 1) ? 1 : 0));
        chk({tag, ".emptyp2"}, 32'(emptyp2), 32'((c <= 2) ? 1 : 0));
        if (stor.size() > 0) chk({tag, ".dout"}, 32'(dout), 32'(stor[0]));
    endtask

    // One clock: apply inputs, advance model, sample 1 time unit after the edge.
    task automatic step(input string tag, input bit w, input bit r, input logic [W-1:0] d);
        wr  = w;
        rd  = r;
        din = d;
        m_step(w, r, d);
        @(posedge clk);
        #1;
        chk_all(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        wr = 1'b1;
        rd = 1'b1;
        din = 16'hFFFF;
        m_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst.count",  32'(count),  32'd0);
        chk("rst.ncount", 32'(ncount), 32'd9);
        chk("rst.empty",  32'(empty),  32'd1);
        chk("rst.full",   32'(full),   32'd0);
        chk("rst.dout",   32'(dout),   32'd0);
        wr = 1'b0;
        rd = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] hd;
        rst_n = 1'b1;
        wr = 1'b0;
        rd = 1'b0;
        din = '0;
        m_reset();
        #2;
        do_reset();
        chk("rst.fullm1",  32'(fullm1),  32'd0);
        chk("rst.emptyp2", 32'(emptyp2), 32'd1);

        // Single write: not readable after first edge, readable after second.
        step("t2a", 1, 0, 16'hA5A5);
        chk("t2.empty_t",  32'(empty), 32'd1);
        step("t2b", 0, 0, 16'h0000);
        chk("t2.empty_t1", 32'(empty), 32'd0);
        chk("t2.dout",     32'(dout),  32'h0000A5A5);
        chk("t2.count",    32'(count), 32'd1);
        step("t2c", 0, 1, 16'h0000);

        // Fill to capacity with 1..9, drop a tenth, drain in order.
        for (int i = 1; i <= 9; i++) step("t3w", 1, 0, 16'(i));
        chk("t3.full",  32'(full),  32'd1);
        chk("t3.count", 32'(count), 32'd9);
        step("t3drop", 1, 0, 16'h00AA);
        chk("t3.count_drop", 32'(count), 32'd9);
        for (int i = 1; i <= 9; i++) begin
            chk("t3.order", 32'(dout), 32'(i));
            step("t3r", 0, 1, 16'h0000);
        end
        chk("t3.empty", 32'(empty), 32'd1);

        // Full with simultaneous wr/rd: pop taken, write dropped.
        for (int i = 0; i < 9; i++) step("t4w", 1, 0, 16'h0100 + 16'(i));
        step("t4rw", 1, 1, 16'hBEEF);
        chk("t4.count", 32'(count), 32'd8);
        chk("t4.full",  32'(full),  32'd0);
        step("t4idle", 0, 0, 16'h0000);
        chk("t4.empty", 32'(empty), 32'd0);
        for (int i = 0; i < 8; i++) step("t4r", 0, 1, 16'h0000);

        // Steady state at count 4 with continuous wr/rd.
        for (int i = 0; i < 4; i++) step("t5w", 1, 0, 16'h0200 + 16'(i));
        step("t5idle", 0, 0, 16'h0000);
        for (int i = 0; i < 20; i++) begin
            step("t5rw", 1, 1, 16'h0300 + 16'(i));
            chk("t5.count", 32'(count), 32'd4);
        end
        for (int i = 0; i < 4; i++) step("t5r", 0, 1, 16'h0000);

        // Asynchronous reset mid-operation at count 5.
        for (int i = 0; i < 5; i++) step("t6w", 1, 0, 16'h0400 + 16'(i));
        chk("t6.count_pre", 32'(count), 32'd5);
        #2;
        rst_n = 1'b0;
        m_reset();
        #1;
        chk("t6.count",  32'(count),  32'd0);
        chk("t6.ncount", 32'(ncount), 32'd9);
        chk("t6.empty",  32'(empty),  32'd1);
        chk("t6.dout",   32'(dout),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step("t6w2", 1, 0, 16'h1234);
        step("t6i",  0, 0, 16'h0000);
        chk("t6.dout_post", 32'(dout), 32'h00001234);
        step("t6r",  0, 1, 16'h0000);

        // Random traffic against the model, with varying read/write bias.
        for (int i = 0; i < 600; i++) begin
            int wb;
            int rb;
            wb = (i < 200) ? 70 : ((i < 400) ? 30 : 50);
            rb = (i < 200) ? 30 : ((i < 400) ? 70 : 50);
            step("rnd",
                 ($urandom_range(99) < wb) ? 1'b1 : 1'b0,
                 ($urandom_range(99) < rb) ? 1'b1 : 1'b0,
                 16'($urandom()));
        end

        hd = dout;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
